// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive sequencer: rx enable / RTS flow control plus a FWFT frame FIFO with error flags.
// Optional character timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo_ctrl #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned RTS_HIGH = 12,
    parameter int unsigned RTS_LOW  = 4,
    parameter int unsigned TO_BITS  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       rx_enable_i,
    input  logic                       flush_i,
    input  logic [7:0]                 data_i,
    input  logic                       data_valid_i,
    input  logic                       parity_err_i,
    input  logic                       stop_bit_err_i,
    input  logic                       tick_i,
    input  logic                       rd_en_i,
    output logic [7:0]                 rd_data_o,
    output logic [1:0]                 rd_err_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       overrun_o,
    input  logic                       clr_overrun_i,
    output logic                       rx_en_o,
    output logic                       rts_no,
    output logic                       timeout_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic [1:0]    state_q, state_d;
    logic          rx_en_q, rx_en_d;
    logic          rts_n_q, rts_n_d;
    logic          push, pop, drop;
    logic          empty, full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A full FIFO still accepts a frame when the head is popped in the same cycle.
    assign push = data_valid_i & rx_en_q & (~full | rd_en_i);
    assign pop  = rd_en_i & ~empty;
    assign drop = data_valid_i & rx_en_q & full & ~rd_en_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (clr_overrun_i) overrun_d = 1'b0;
        if (drop)          overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push && !flush_i) mem[wr_ptr_q] <= {stop_bit_err_i, parity_err_i, data_i};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Disable has priority over the flow-control transitions in every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_enable_i) begin
                    state_d = (count_q >= CW'(RTS_HIGH)) ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!rx_enable_i)                  state_d = ST_IDLE;
                else if (count_q >= CW'(RTS_HIGH)) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!rx_enable_i)                 state_d = ST_IDLE;
                else if (count_q <= CW'(RTS_LOW)) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_en_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
        rts_n_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rx_en_q <= 1'b0;
            rts_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            rx_en_q <= rx_en_d;
            rts_n_q <= rts_n_d;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned BW = $clog2(TO_BITS + 1);

    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          timeout_q, timeout_d;
    logic          to_clear;

    assign to_clear = push | pop | flush_i | empty;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        timeout_d  = timeout_q;
        if (to_clear) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            timeout_d  = 1'b0;
        end else begin
            if (tick_i) begin
                tick_cnt_d = tick_cnt_q + 1'b1;
                if (tick_cnt_q == 4'hf && bit_cnt_q != BW'(TO_BITS)) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            if (bit_cnt_q == BW'(TO_BITS)) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_to;
    assign unused_to = tick_i;
    assign timeout_o = 1'b0;
`endif

    logic [9:0] head;
    assign head = empty ? 10'd0 : mem[rd_ptr_q];

    assign rd_data_o = head[7:0];
    assign rd_err_o  = head[9:8];
    assign count_o   = count_q;
    assign empty_o   = empty;
    assign full_o    = full;
    assign overrun_o = overrun_q;
    assign rx_en_o   = rx_en_q;
    assign rts_no    = rts_n_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboard bench for uart_rx_fifo_ctrl (DEPTH=16, RTS 12/4, TO_BITS=4).
module tb_uart_rx_fifo_ctrl;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_enable_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       data_valid_i = 1'b0;
    logic       parity_err_i = 1'b0;
    logic       stop_bit_err_i = 1'b0;
    logic       tick_i = 1'b0;
    logic       rd_en_i = 1'b0;
    logic       clr_overrun_i = 1'b0;
    logic [7:0] rd_data_o;
    logic [1:0] rd_err_o;
    logic [4:0] count_o;
    logic       empty_o, full_o, overrun_o, rx_en_o, rts_no, timeout_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [9:0] sb[$];
    logic rx_on = 1'b0;

    uart_rx_fifo_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_enable_i    (rx_enable_i),
        .flush_i        (flush_i),
        .data_i         (data_i),
        .data_valid_i   (data_valid_i),
        .parity_err_i   (parity_err_i),
        .stop_bit_err_i (stop_bit_err_i),
        .tick_i         (tick_i),
        .rd_en_i        (rd_en_i),
        .rd_data_o      (rd_data_o),
        .rd_err_o       (rd_err_o),
        .count_o        (count_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .overrun_o      (overrun_o),
        .clr_overrun_i  (clr_overrun_i),
        .rx_en_o        (rx_en_o),
        .rts_no         (rts_no),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare the FWFT head against the scoreboard front (zeros when empty).
    task automatic check_head(input string tag);
        logic [9:0] e;
        e = (sb.size() == 0) ? 10'd0 : sb[0];
        check({tag, "_data"}, 32'(rd_data_o), 32'(e[7:0]));
        check({tag, "_err"}, 32'(rd_err_o), 32'(e[9:8]));
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic send(input logic [7:0] d, input logic pe, input logic se, input logic with_pop);
        bit accept, popped;
        popped = with_pop && (sb.size() > 0);
        accept = rx_on && ((sb.size() < DEPTH) || with_pop);
        if (popped) check_head("pp_head");
        data_i = d; parity_err_i = pe; stop_bit_err_i = se;
        data_valid_i = 1'b1; rd_en_i = with_pop;
        @(negedge clk);
        data_valid_i = 1'b0; rd_en_i = 1'b0;
        if (popped) void'(sb.pop_front());
        if (accept) sb.push_back({se, pe, d});
        check("count", 32'(count_o), 32'(sb.size()));
    endtask

    task automatic pop_one();
        check_head("head");
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        check("count", 32'(count_o), 32'(sb.size()));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        // Reset state
        check("rst_count", 32'(count_o), 0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_full", 32'(full_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        check("rst_rx_en", 32'(rx_en_o), 0);
        check("rst_rts", 32'(rts_no), 1);
        check("rst_timeout", 32'(timeout_o), 0);
        check_head("rst_head");
        reset_n = 1'b1;
        @(negedge clk);

        // 1: enable -> RUN one cycle later
        rx_enable_i = 1'b1;
        @(negedge clk);
        rx_on = 1'b1;
        check("t1_rx_en", 32'(rx_en_o), 1);
        check("t1_rts", 32'(rts_no), 0);
        check("t1_empty", 32'(empty_o), 1);

        // 2: push with rd_en while empty is a push only; then head ordering and error flags
        send(8'h5A, 1'b1, 1'b0, 1'b1);
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        check("t2_head_data", 32'(rd_data_o), 32'h5A);
        check("t2_head_err", 32'(rd_err_o), 32'h1);
        pop_one();
        check("t2_next_data", 32'(rd_data_o), 32'h3C);
        check("t2_next_err", 32'(rd_err_o), 32'h0);
        pop_one();
        check("t2_empty", 32'(empty_o), 1);

        // 3: RTS hysteresis
        for (int i = 0; i < 12; i++) send(8'(8'h10 + i), 1'(i % 2), 1'(i % 3 == 0), 1'b0);
        @(negedge clk);
        check("t3_rts_high", 32'(rts_no), 1);
        check("t3_rx_en_hold", 32'(rx_en_o), 1);
        for (int i = 0; i < 8; i++) pop_one();
        @(negedge clk);
        check("t3_rts_low", 32'(rts_no), 0);

        // 4: fill, drop on overrun, clear, push+pop at full, set-wins
        for (int i = 0; i < 12; i++) send(8'(8'h80 + i), 1'b0, 1'(i % 2), 1'b0);
        check("t4_full", 32'(full_o), 1);
        send(8'hFF, 1'b1, 1'b1, 1'b0);
        check("t4_overrun", 32'(overrun_o), 1);
        check_head("t4_head_kept");
        clr_overrun_i = 1'b1;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        check("t4_ovr_clr", 32'(overrun_o), 0);
        send(8'hA5, 1'b0, 1'b1, 1'b1);
        check("t4_pp_overrun", 32'(overrun_o), 0);
        check("t4_pp_full", 32'(full_o), 1);
        clr_overrun_i = 1'b1;
        send(8'h77, 1'b0, 1'b0, 1'b0);
        clr_overrun_i = 1'b0;
        check("t4_set_wins", 32'(overrun_o), 1);

        // 5: disable retains contents, flush clears
        while (sb.size() > 3) pop_one();
        rx_enable_i = 1'b0;
        @(negedge clk);
        rx_on = 1'b0;
        check("t5_rx_en", 32'(rx_en_o), 0);
        check("t5_rts", 32'(rts_no), 1);
        check("t5_count", 32'(count_o), 3);
        send(8'h42, 1'b0, 1'b0, 1'b0);
        check_head("t5_head");
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        sb.delete();
        check("t5_flush_count", 32'(count_o), 0);
        check("t5_flush_empty", 32'(empty_o), 1);
        check("t5_flush_ovr", 32'(overrun_o), 1);

        // 6: character timeout
        rx_enable_i = 1'b1;
        @(negedge clk);
        rx_on = 1'b1;
        send(8'hC3, 1'b0, 1'b0, 1'b0);
        tick_i = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_no_to_early", 32'(timeout_o), 0);
        repeat (4) @(negedge clk);
        tick_i = 1'b0;
        repeat (2) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
        check("t6_timeout", 32'(timeout_o), 1);
`else
        check("t6_timeout", 32'(timeout_o), 0);
`endif
        pop_one();
        check("t6_to_clear", 32'(timeout_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
